// File: rtl/mdio_access_arbiter_if.sv
// Signal bundle between the two MDIO requesters, the access arbiter and the MDIO engine.
// The slave modport is the arbiter's view. The master modport is the surrounding environment.
interface mdio_access_arbiter_if;
   logic        req0_valid;
   logic        req0_wr;
   logic [4:0]  req0_phy;
   logic [4:0]  req0_reg;
   logic [15:0] req0_wdata;
   logic        req0_ready;
   logic        req0_done;
   logic        req0_err;
   logic [15:0] req0_rdata;

   logic        req1_valid;
   logic        req1_wr;
   logic [4:0]  req1_phy;
   logic [4:0]  req1_reg;
   logic [15:0] req1_wdata;
   logic        req1_ready;
   logic        req1_done;
   logic        req1_err;
   logic [15:0] req1_rdata;

   logic        mst_start;
   logic        mst_wr;
   logic [4:0]  mst_phy;
   logic [4:0]  mst_reg;
   logic [15:0] mst_wdata;
   logic        mst_busy;
   logic        mst_done;
   logic [15:0] mst_rdata;

   logic        arb_busy;
   logic        grant_id;

   modport slave (
      input  req0_valid, req0_wr, req0_phy, req0_reg, req0_wdata,
      input  req1_valid, req1_wr, req1_phy, req1_reg, req1_wdata,
      input  mst_busy, mst_done, mst_rdata,
      output req0_ready, req0_done, req0_err, req0_rdata,
      output req1_ready, req1_done, req1_err, req1_rdata,
      output mst_start, mst_wr, mst_phy, mst_reg, mst_wdata,
      output arb_busy, grant_id
   );

   modport master (
      output req0_valid, req0_wr, req0_phy, req0_reg, req0_wdata,
      output req1_valid, req1_wr, req1_phy, req1_reg, req1_wdata,
      output mst_busy, mst_done, mst_rdata,
      input  req0_ready, req0_done, req0_err, req0_rdata,
      input  req1_ready, req1_done, req1_err, req1_rdata,
      input  mst_start, mst_wr, mst_phy, mst_reg, mst_wdata,
      input  arb_busy, grant_id
   );
endinterface

// File: rtl/mdio_access_arbiter.sv
// Round-robin arbiter sharing one MDIO register-access engine between two requesters:
// launches one command at a time and returns read data or a timeout error to the winner.
//
// state | meaning
// IDLE  | waiting for a request while the engine is not busy
// ISSUE | start pulse to engine, ready pulse to winner, timeout counter cleared
// WAIT  | engine running, counting toward the timeout
// RESP  | done pulse with err/rdata to the winner
module mdio_access_arbiter #(
   parameter int unsigned TIMEOUT_CYC = 2_000_000
) (
   input logic                  clk,
   input logic                  rst,
   mdio_access_arbiter_if.slave bus
);
   localparam int unsigned      CNT_W  = $clog2(TIMEOUT_CYC);
   localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(TIMEOUT_CYC - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic             last_grant_q, last_grant_d;
   logic             grant_q, grant_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             wr_q, wr_d;
   logic [4:0]       phy_q, phy_d;
   logic [4:0]       reg_q, reg_d;
   logic [15:0]      wdata_q, wdata_d;
   logic             start_q, start_d;
   logic [1:0]       ready_q, ready_d;
   logic [1:0]       done_q, done_d;
   logic [1:0]       err_q, err_d;
   logic [15:0]      rdata0_q, rdata0_d;
   logic [15:0]      rdata1_q, rdata1_d;
   logic             busy_q, busy_d;

   logic             winner;
   logic             launch;
   logic             timeout_hit;
   logic             finish;
   logic [15:0]      rsp_rdata;

   // With both pending, the requester that did not win last time goes next.
   assign winner      = (bus.req0_valid && bus.req1_valid) ? ~last_grant_q : bus.req1_valid;
   assign launch      = (state_q == S_IDLE) && !bus.mst_busy && (bus.req0_valid || bus.req1_valid);
   assign timeout_hit = (cnt_q == CNT_TC);
   assign finish      = (state_q == S_WAIT) && (bus.mst_done || timeout_hit);
   assign rsp_rdata   = (bus.mst_done && !wr_q) ? bus.mst_rdata : 16'h0000;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         last_grant_q <= 1'b1;
         grant_q      <= 1'b0;
         cnt_q        <= '0;
         wr_q         <= 1'b0;
         phy_q        <= 5'd0;
         reg_q        <= 5'd0;
         wdata_q      <= 16'h0000;
         start_q      <= 1'b0;
         ready_q      <= 2'b00;
         done_q       <= 2'b00;
         err_q        <= 2'b00;
         rdata0_q     <= 16'h0000;
         rdata1_q     <= 16'h0000;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         grant_q      <= grant_d;
         cnt_q        <= cnt_d;
         wr_q         <= wr_d;
         phy_q        <= phy_d;
         reg_q        <= reg_d;
         wdata_q      <= wdata_d;
         start_q      <= start_d;
         ready_q      <= ready_d;
         done_q       <= done_d;
         err_q        <= err_d;
         rdata0_q     <= rdata0_d;
         rdata1_q     <= rdata1_d;
         busy_q       <= busy_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (launch) state_d = S_ISSUE;
         S_ISSUE: state_d = S_WAIT;
         S_WAIT:  if (finish) state_d = S_RESP;
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      last_grant_d = last_grant_q;
      grant_d      = grant_q;
      cnt_d        = cnt_q;
      wr_d         = wr_q;
      phy_d        = phy_q;
      reg_d        = reg_q;
      wdata_d      = wdata_q;
      start_d      = 1'b0;
      ready_d      = 2'b00;
      done_d       = 2'b00;
      err_d        = 2'b00;
      rdata0_d     = rdata0_q;
      rdata1_d     = rdata1_q;
      busy_d       = (state_d != S_IDLE);

      case (state_q)
         S_IDLE: begin
            if (launch) begin
               last_grant_d    = winner;
               grant_d         = winner;
               wr_d            = winner ? bus.req1_wr    : bus.req0_wr;
               phy_d           = winner ? bus.req1_phy   : bus.req0_phy;
               reg_d           = winner ? bus.req1_reg   : bus.req0_reg;
               wdata_d         = winner ? bus.req1_wdata : bus.req0_wdata;
               start_d         = 1'b1;
               ready_d[winner] = 1'b1;
            end
         end
         S_ISSUE: cnt_d = '0;
         S_WAIT: begin
            cnt_d = cnt_q + 1'b1;
            // Engine completion takes priority over a coincident terminal count.
            if (finish) begin
               done_d[grant_q] = 1'b1;
               err_d[grant_q]  = !bus.mst_done;
               if (grant_q) rdata1_d = rsp_rdata;
               else         rdata0_d = rsp_rdata;
            end
         end
         default: ;
      endcase
   end

   assign bus.req0_ready = ready_q[0];
   assign bus.req1_ready = ready_q[1];
   assign bus.req0_done  = done_q[0];
   assign bus.req1_done  = done_q[1];
   assign bus.req0_err   = err_q[0];
   assign bus.req1_err   = err_q[1];
   assign bus.req0_rdata = rdata0_q;
   assign bus.req1_rdata = rdata1_q;
   assign bus.mst_start  = start_q;
   assign bus.mst_wr     = wr_q;
   assign bus.mst_phy    = phy_q;
   assign bus.mst_reg    = reg_q;
   assign bus.mst_wdata  = wdata_q;
   assign bus.arb_busy   = busy_q;
   assign bus.grant_id   = grant_q;
endmodule

// File: tb/tb_mdio_access_arbiter.sv
// Scoreboard bench for mdio_access_arbiter: directed commands push expected issue and
// response records; a monitor pops and compares them whenever the arbiter presents them.
module tb_mdio_access_arbiter;
   localparam int unsigned T_CYC = 10;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   mdio_access_arbiter_if bus ();
   mdio_access_arbiter #(.TIMEOUT_CYC(T_CYC)) dut (.clk(clk), .rst(rst), .bus(bus));

   typedef struct packed {
      logic        wr;
      logic [4:0]  phy;
      logic [4:0]  rg;
      logic [15:0] wdata;
   } cmd_t;
   typedef struct { int id; cmd_t c; } iss_t;
   typedef struct { int id; logic err; logic [15:0] rdata; int dly; } rsp_t;

   cmd_t cmdq0[$];
   cmd_t cmdq1[$];
   iss_t issq[$];
   rsp_t rspq[$];
   int   start_log[$];
   logic [1:0] rv = 2'b00;
   int   n_chk = 0;
   int   n_pass = 0;
   int   last_start = 0;
   int   eng_lat = 5;
   int   eng_cnt = 0;
   logic eng_pend = 1'b0;
   logic [15:0] eng_rd = 16'h0000;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
   endtask

   function automatic cmd_t mk(input logic wr, input int phy, input int rg, input logic [15:0] wd);
      cmd_t c;
      c.wr = wr; c.phy = 5'(phy); c.rg = 5'(rg); c.wdata = wd;
      return c;
   endfunction

   function automatic logic [67:0] outs();
      return {bus.req0_ready, bus.req1_ready, bus.req0_done, bus.req1_done, bus.req0_err,
              bus.req1_err, bus.req0_rdata, bus.req1_rdata, bus.mst_start, bus.mst_wr,
              bus.mst_phy, bus.mst_reg, bus.mst_wdata, bus.arb_busy, bus.grant_id};
   endfunction

   task automatic set_req(input int p, input logic v, input cmd_t c);
      if (p == 0) begin
         bus.req0_valid = v; bus.req0_wr = c.wr; bus.req0_phy = c.phy;
         bus.req0_reg = c.rg; bus.req0_wdata = c.wdata;
      end else begin
         bus.req1_valid = v; bus.req1_wr = c.wr; bus.req1_phy = c.phy;
         bus.req1_reg = c.rg; bus.req1_wdata = c.wdata;
      end
      rv[p] = v;
   endtask

   function automatic logic get_rdy(input int p);
      return (p == 0) ? bus.req0_ready : bus.req1_ready;
   endfunction

   function automatic logic qhas(input int p);
      return (p == 0) ? (cmdq0.size() != 0) : (cmdq1.size() != 0);
   endfunction

   task automatic pop_drive(input int p);
      cmd_t c;
      if (p == 0) c = cmdq0.pop_front();
      else        c = cmdq1.pop_front();
      set_req(p, 1'b1, c);
   endtask

   // Requester: holds valid and fields until ready, then presents its next command at once.
   task automatic drive(input int p);
      forever begin
         @(posedge clk); #1;
         if (rv[p] && get_rdy(p)) begin
            if (qhas(p)) pop_drive(p);
            else         set_req(p, 1'b0, '0);
         end else if (!rv[p] && qhas(p)) begin
            pop_drive(p);
         end
      end
   endtask

   initial drive(0);
   initial drive(1);

   task automatic push(input int p, input cmd_t c, input logic err, input logic [15:0] rd,
                       input int dly);
      iss_t e;
      rsp_t r;
      if (p == 0) cmdq0.push_back(c);
      else        cmdq1.push_back(c);
      e.id = p; e.c = c; issq.push_back(e);
      r.id = p; r.err = err; r.rdata = rd; r.dly = dly; rspq.push_back(r);
   endtask

   task automatic push_issue_only(input int p, input cmd_t c);
      iss_t e;
      if (p == 0) cmdq0.push_back(c);
      else        cmdq1.push_back(c);
      e.id = p; e.c = c; issq.push_back(e);
   endtask

   function automatic logic idle_now();
      return issq.size() == 0 && rspq.size() == 0 && cmdq0.size() == 0 && cmdq1.size() == 0
             && rv == 2'b00 && !bus.arb_busy && !eng_pend;
   endfunction

   task automatic drain(input string nm, input int budget);
      int n = 0;
      while (!idle_now() && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk({nm, "_drain"}, 128'(idle_now()), 128'd1);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Engine model: mst_done eng_lat cycles after mst_start; rdata is junk outside the done cycle.
   initial begin
      bus.mst_done  = 1'b0;
      bus.mst_rdata = 16'hDEAD;
      forever begin
         @(posedge clk); #1;
         bus.mst_done  = 1'b0;
         bus.mst_rdata = 16'hDEAD;
         if (rst) begin
            eng_pend = 1'b0;
         end else begin
            if (eng_pend) begin
               eng_cnt--;
               if (eng_cnt == 0) begin
                  bus.mst_done  = 1'b1;
                  bus.mst_rdata = eng_rd;
                  eng_pend      = 1'b0;
               end
            end
            if (bus.mst_start) begin
               eng_pend = 1'b1;
               eng_cnt  = eng_lat;
            end
         end
      end
   end

   initial begin : monitor
      iss_t e;
      rsp_t r;
      forever begin
         @(negedge clk);
         if (bus.mst_start) begin
            start_log.push_back(cyc);
            last_start = cyc;
            chk("issue_expected", 128'(issq.size() != 0), 128'd1);
            if (issq.size() != 0) begin
               e = issq.pop_front();
               chk($sformatf("issue_req%0d", e.id),
                   128'({bus.grant_id, bus.req1_ready, bus.req0_ready, bus.mst_wr, bus.mst_phy,
                         bus.mst_reg, bus.mst_wdata}),
                   128'({e.id[0], e.id == 1, e.id == 0, e.c}));
            end
         end else if (bus.req0_ready || bus.req1_ready) begin
            chk("ready_with_start", 128'(bus.mst_start), 128'd1);
         end
         for (int p = 0; p < 2; p++) begin
            if ((p == 0) ? bus.req0_done : bus.req1_done) begin
               chk("done_expected", 128'(rspq.size() != 0), 128'd1);
               if (rspq.size() != 0) begin
                  r = rspq.pop_front();
                  chk($sformatf("done_req%0d", p),
                      128'({1'(p), (p == 0) ? bus.req0_err : bus.req1_err,
                            (p == 0) ? bus.req0_rdata : bus.req1_rdata, 8'(cyc - last_start)}),
                      128'({r.id[0], r.err, r.rdata, 8'(r.dly)}));
               end
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n0;
      int b;
      int n;
      bus.mst_busy = 1'b0;
      set_req(0, 1'b0, '0);
      set_req(1, 1'b0, '0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("reset_outputs", 128'(outs()), 128'd0);

      // Single read: done one cycle after mst_done, i.e. latency+1 after start.
      @(negedge clk);
      eng_lat = 5; eng_rd = 16'h0141;
      push(0, mk(1'b0, 1, 2, 16'h0000), 1'b0, 16'h0141, 6);
      drain("single", 100);
      repeat (3) @(negedge clk);
      chk("single_rdata_hold", 128'(bus.req0_rdata), 128'h0141);
      chk("single_req1_quiet", 128'(bus.req1_rdata), 128'h0);

      // Contention right after reset: req0 first, then req1 (a write returns zero data).
      do_reset();
      eng_lat = 4; eng_rd = 16'h1234;
      push(0, mk(1'b0, 3, 1, 16'h0000), 1'b0, 16'h1234, 5);
      push(1, mk(1'b1, 4, 0, 16'hCAFE), 1'b0, 16'h0000, 5);
      drain("contention", 100);

      // Fairness: both stay valid for three commands each; grants alternate 0,1,...
      @(negedge clk);
      eng_lat = 3; eng_rd = 16'h0F0F;
      n0 = start_log.size();
      for (int k = 0; k < 3; k++) begin
         for (int p = 0; p < 2; p++) begin
            push(p, mk(k == 1, 8 * p + k, k + 4, 16'hA000 + 16'(4 * k + p)), 1'b0,
                 (k == 1) ? 16'h0000 : 16'h0F0F, 4);
         end
      end
      drain("fairness", 200);
      chk("fairness_starts", 128'(start_log.size()), 128'(n0 + 6));
      // mst_done at S+lat, RESP, IDLE, then the next start.
      if (start_log.size() >= n0 + 6) begin
         for (int i = 1; i < 6; i++)
            chk($sformatf("start_spacing_%0d", i),
                128'(start_log[n0 + i] - start_log[n0 + i - 1]), 128'(eng_lat + 3));
      end

      // Busy gating.
      @(negedge clk);
      eng_lat = 3; eng_rd = 16'h7777;
      bus.mst_busy = 1'b1;
      push(1, mk(1'b0, 2, 1, 16'h0000), 1'b0, 16'h7777, 4);
      n0 = start_log.size();
      repeat (6) @(negedge clk);
      chk("busy_no_start", 128'(start_log.size()), 128'(n0));
      chk("busy_arb_idle", 128'(bus.arb_busy), 128'd0);
      @(posedge clk); #1;
      bus.mst_busy = 1'b0;
      b = cyc;
      drain("busy", 100);
      chk("busy_release_start", 128'(last_start), 128'(b + 1));

      // Timeout: engine answers one cycle too late, which must be ignored.
      @(negedge clk);
      eng_lat = 11; eng_rd = 16'h9999;
      push(0, mk(1'b0, 5, 9, 16'h0000), 1'b1, 16'h0000, T_CYC + 1);
      drain("timeout", 100);
      repeat (4) @(negedge clk);
      chk("timeout_rdata_hold", 128'(bus.req0_rdata), 128'h0);

      // mst_done on the terminal-count cycle wins.
      eng_lat = 10; eng_rd = 16'hBEEF;
      push(1, mk(1'b0, 6, 3, 16'h0000), 1'b0, 16'hBEEF, T_CYC + 1);
      drain("tc_and_done", 100);

      // Reset mid-WAIT after req1 has left nonzero state behind.
      @(negedge clk);
      eng_lat = 4; eng_rd = 16'h5A5A;
      push(1, mk(1'b0, 7, 7, 16'h0000), 1'b0, 16'h5A5A, 5);
      drain("pre_reset", 100);
      eng_lat = 8;
      n0 = start_log.size();
      push_issue_only(1, mk(1'b1, 9, 10, 16'h1357));
      n = 0;
      while (start_log.size() == n0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("rst_cmd_started", 128'(start_log.size()), 128'(n0 + 1));
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst_wait_outputs", 128'(outs()), 128'd0);
      repeat (12) @(negedge clk);
      chk("rst_no_activity", 128'({bus.arb_busy, bus.req1_rdata}), 128'd0);
      eng_lat = 2; eng_rd = 16'h0042;
      push(0, mk(1'b0, 1, 1, 16'h0000), 1'b0, 16'h0042, 3);
      push(1, mk(1'b1, 2, 2, 16'h2468), 1'b0, 16'h0000, 3);
      drain("post_reset_contention", 100);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
